// File: rtl/fec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fec_pkg                                                |
// | Description : Shared constants, FSM state type and index-width       |
// |               helper for the 2D-parity FEC receive framer.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fec_pkg;

   localparam int FEC_WIDTH   = 4;   // data words (rows) per frame
   localparam int FEC_DEPTH   = 4;   // bits per data word
   localparam int FEC_TIMEOUT = 64;  // cycles allowed for decoder done

   // Explicitly encoded so the state register width is fixed and visible
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COLLECT   = 3'd1,
      PARITY    = 3'd2,
      START     = 3'd3,
      WAIT_DONE = 3'd4,
      DRAIN     = 3'd5
   } state_t;

   // Row index width; never narrower than one bit so a 1-row frame still works
   function automatic int fec_idx_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sat_counter                                            |
// | Description : Up-counter that sticks at all-ones instead of wrapping.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   // Increment on request unless already saturated
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fec_rx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fec_rx_framer                                          |
// | Description : Gathers WIDTH data beats plus a parity beat, hands the |
// |               matrix to the 2D-parity decoder, waits for done (with  |
// |               timeout) and streams the corrected rows with status.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fec_rx_framer
   import fec_pkg::*;
#(
   parameter int WIDTH   = FEC_WIDTH,
   parameter int DEPTH   = FEC_DEPTH,
   parameter int TIMEOUT = FEC_TIMEOUT,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DEPTH-1:0]       in_data,
   input  logic [WIDTH-1:0]       in_col_par,
   output logic [WIDTH*DEPTH-1:0] dec_data,
   output logic [DEPTH-1:0]       dec_row_par,
   output logic [WIDTH-1:0]       dec_col_par,
   output logic                   dec_start,
   input  logic                   dec_done,
   input  logic [WIDTH*DEPTH-1:0] dec_data_corr,
   input  logic                   dec_err_det,
   input  logic                   dec_err_corr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DEPTH-1:0]       out_data,
   output logic                   out_last,
   output logic                   out_err_det,
   output logic                   out_err_uncorr,
   output logic [CNT_W-1:0]       frame_cnt,
   output logic [CNT_W-1:0]       uncorr_cnt,
   output logic [CNT_W-1:0]       timeout_cnt
);

   localparam int IDX_W = fec_idx_w(WIDTH);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WIDTH - 1);

   state_t                      state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;      // input row while filling, output row while draining
   logic [WIDTH-1:0][DEPTH-1:0] mat_q, mat_d;      // raw received matrix
   logic [WIDTH-1:0][DEPTH-1:0] cap_q, cap_d;      // rows to emit (corrected or raw)
   logic [DEPTH-1:0]            row_par_q, row_par_d;
   logic [WIDTH-1:0]            col_par_q, col_par_d;
   logic [TMO_W-1:0]            tmo_q, tmo_d;
   logic                        done_prev_q;
   logic                        err_det_q, err_det_d;
   logic                        err_unc_q, err_unc_d;

   logic w_drain, w_in_fire, w_out_fire, w_done_rise, w_timeout, w_frame_end;

   // Handshake and status decode; in_ready is held low while reset is asserted
   assign in_ready    = ~rst & ((state_q == IDLE) | (state_q == COLLECT) | (state_q == PARITY));
   assign w_in_fire   = in_valid & in_ready;
   assign w_drain     = (state_q == DRAIN);
   assign w_out_fire  = out_valid & out_ready;
   assign w_done_rise = dec_done & ~done_prev_q;
   // A done edge in the final cycle takes priority over the expiry
   assign w_timeout   = (state_q == WAIT_DONE) & ~w_done_rise & (tmo_q <= TMO_W'(1));
   assign w_frame_end = w_out_fire & out_last;

   assign dec_data       = mat_q;
   assign dec_row_par    = row_par_q;
   assign dec_col_par    = col_par_q;
   assign dec_start      = (state_q == START);
   assign out_valid      = w_drain;
   assign out_data       = w_drain ? cap_q[idx_q] : '0;
   assign out_last       = w_drain & (idx_q == c_last_idx);
   assign out_err_det    = w_drain & err_det_q;
   assign out_err_uncorr = w_drain & err_unc_q;

   // Next-state logic for the frame FSM and its datapath registers
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mat_d     = mat_q;
      cap_d     = cap_q;
      row_par_d = row_par_q;
      col_par_d = col_par_q;
      tmo_d     = tmo_q;
      err_det_d = err_det_q;
      err_unc_d = err_unc_q;
      case (state_q)
         IDLE: begin
            if (w_in_fire) begin
               mat_d[0] = in_data;
               idx_d    = IDX_W'(1);
               state_d  = (WIDTH == 1) ? PARITY : COLLECT;
            end
         end
         COLLECT: begin
            if (w_in_fire) begin
               mat_d[idx_q] = in_data;
               if (idx_q == c_last_idx) begin
                  idx_d   = '0;
                  state_d = PARITY;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (w_in_fire) begin
               row_par_d = in_data;
               col_par_d = in_col_par;
               state_d   = START;
            end
         end
         START: begin
            tmo_d   = TMO_W'(TIMEOUT);
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (w_done_rise) begin
               cap_d     = dec_data_corr;
               err_det_d = dec_err_det;
               err_unc_d = dec_err_det & ~dec_err_corr;
               idx_d     = '0;
               state_d   = DRAIN;
            end else if (w_timeout) begin
               // Decoder never answered: pass the raw rows and flag them unusable
               cap_d     = mat_q;
               err_det_d = 1'b1;
               err_unc_d = 1'b1;
               tmo_d     = '0;
               idx_d     = '0;
               state_d   = DRAIN;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         DRAIN: begin
            if (w_out_fire) begin
               if (idx_q == c_last_idx) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         mat_q       <= '0;
         cap_q       <= '0;
         row_par_q   <= '0;
         col_par_q   <= '0;
         tmo_q       <= '0;
         done_prev_q <= 1'b0;
         err_det_q   <= 1'b0;
         err_unc_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mat_q       <= mat_d;
         cap_q       <= cap_d;
         row_par_q   <= row_par_d;
         col_par_q   <= col_par_d;
         tmo_q       <= tmo_d;
         done_prev_q <= dec_done;
         err_det_q   <= err_det_d;
         err_unc_q   <= err_unc_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_frame_end),
      .count (frame_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_uncorr_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_frame_end & err_unc_q),
      .count (uncorr_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_timeout),
      .count (timeout_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_fec_rx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fec_rx_framer                                       |
// | Description : Directed and randomized frames through fec_rx_framer  |
// |               with a behavioural stand-in for the 2D-parity decoder. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fec_rx_framer;

   localparam int W    = 4;
   localparam int D    = 4;
   localparam int TMO  = 64;
   localparam int CW   = 3;               // narrow counters so saturation is reachable
   localparam int CMAX = (1 << CW) - 1;

   typedef logic [D-1:0] row_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [D-1:0]   in_data;
   logic [W-1:0]   in_col_par;
   logic [W*D-1:0] dec_data;
   logic [D-1:0]   dec_row_par;
   logic [W-1:0]   dec_col_par;
   logic           dec_start;
   logic           dec_done;
   logic [W*D-1:0] dec_data_corr;
   logic           dec_err_det;
   logic           dec_err_corr;
   logic           out_valid;
   logic           out_ready;
   logic [D-1:0]   out_data;
   logic           out_last;
   logic           out_err_det;
   logic           out_err_uncorr;
   logic [CW-1:0]  frame_cnt;
   logic [CW-1:0]  uncorr_cnt;
   logic [CW-1:0]  timeout_cnt;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int exp_starts = 0;
   int exp_frame = 0;
   int exp_unc = 0;
   int exp_tmo = 0;

   always #5 clk = ~clk;

   fec_rx_framer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_col_par     (in_col_par),
      .dec_data       (dec_data),
      .dec_row_par    (dec_row_par),
      .dec_col_par    (dec_col_par),
      .dec_start      (dec_start),
      .dec_done       (dec_done),
      .dec_data_corr  (dec_data_corr),
      .dec_err_det    (dec_err_det),
      .dec_err_corr   (dec_err_corr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .out_err_det    (out_err_det),
      .out_err_uncorr (out_err_uncorr),
      .frame_cnt      (frame_cnt),
      .uncorr_cnt     (uncorr_cnt),
      .timeout_cnt    (timeout_cnt)
   );

   // Count every cycle the start strobe is seen high
   always @(posedge clk) if (dec_start) start_cnt <= start_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic logic [W*D-1:0] pack(input row_t r[W]);
      logic [W*D-1:0] v;
      v = '0;
      for (int i = 0; i < W; i++) v[i*D +: D] = r[i];
      return v;
   endfunction

   // Even parity: each row XORs to its col_par bit, each bit column to row_par
   function automatic void make_par(input row_t r[W], output row_t rp, output logic [W-1:0] cp);
      rp = '0;
      cp = '0;
      for (int i = 0; i < W; i++) begin
         rp    = rp ^ r[i];
         cp[i] = ^r[i];
      end
   endfunction

   // Decoder stand-in: one failing row and one failing column locate a bit to flip
   function automatic void decode(input row_t r[W], input row_t rp, input logic [W-1:0] cp,
                                  output row_t corr[W], output bit det, output bit cor);
      int nr = 0;
      int nc = 0;
      int ri = 0;
      int cj = 0;
      for (int i = 0; i < W; i++) if ((^r[i]) != cp[i]) begin nr++; ri = i; end
      for (int j = 0; j < D; j++) begin
         logic x;
         x = rp[j];
         for (int i = 0; i < W; i++) x = x ^ r[i][j];
         if (x) begin nc++; cj = j; end
      end
      corr = r;
      det  = (nr + nc) != 0;
      cor  = 1'b0;
      if (nr == 1 && nc == 1) begin
         corr[ri][cj] = ~corr[ri][cj];
         cor = 1'b1;
      end else if (nr + nc == 1) begin
         cor = 1'b1;   // lone parity-bit error, data already correct
      end
   endfunction

   task automatic send_beat(input row_t d, input logic [W-1:0] cp);
      int g = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid   = 1'b1;
      in_data    = d;
      in_col_par = cp;
      while (!in_ready && g < 20) begin @(negedge clk); g++; end
      chk("in_ready_accept", in_ready, 1);
      @(negedge clk);
      in_valid   = 1'b0;
      in_data    = row_t'($urandom);
      in_col_par = W'($urandom);
   endtask

   task automatic drain_frame(input row_t exp_rows[W], input bit e_det, input bit e_unc, input int stall_at);
      int k = 0;
      int g = 0;
      while (k < W && g < 400) begin
         if (out_valid) begin
            chk("out_data", out_data, exp_rows[k]);
            chk("out_last", out_last, (k == W - 1));
            chk("out_err_det", out_err_det, e_det);
            chk("out_err_uncorr", out_err_uncorr, e_unc);
            chk("in_ready_drain", in_ready, 0);
            if (k == stall_at) begin
               out_ready = 1'b0;
               repeat (5) begin
                  @(negedge clk);
                  chk("hold_valid", out_valid, 1);
                  chk("hold_data", out_data, exp_rows[k]);
                  chk("hold_last", out_last, (k == W - 1));
                  chk("hold_in_ready", in_ready, 0);
               end
               stall_at = -1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_ready) k++;
         end else begin
            out_ready = 1'b0;
         end
         @(negedge clk);
         g++;
      end
      out_ready = 1'b0;
      chk("drain_beats", k, W);
   endtask

   task automatic run_frame(input row_t rows[W], input row_t rp, input logic [W-1:0] cp,
                            input bit dec_on, input int stall_at, input bit junk);
      row_t exp_rows[W];
      bit   det, cor, e_det, e_unc;
      int   g = 0;
      decode(rows, rp, cp, exp_rows, det, cor);
      if (dec_on) begin
         e_det = det;
         e_unc = det & !cor;
      end else begin
         exp_rows = rows;
         e_det    = 1'b1;
         e_unc    = 1'b1;
      end
      for (int i = 0; i < W; i++) send_beat(rows[i], W'($urandom));
      send_beat(rp, cp);
      while (!dec_start && g < 10) begin @(negedge clk); g++; end
      chk("dec_start_seen", dec_start, 1);
      exp_starts++;
      chk("dec_data", dec_data, pack(rows));
      chk("dec_row_par", dec_row_par, rp);
      chk("dec_col_par", dec_col_par, cp);
      chk("in_ready_start", in_ready, 0);
      if (junk) begin
         // Held beat must not be swallowed while the framer is busy
         in_valid = 1'b1;
         in_data  = ~rows[0];
      end
      @(negedge clk);
      chk("start_one_cycle", dec_start, 0);
      if (dec_on) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         dec_data_corr = pack(exp_rows);
         dec_err_det   = det;
         dec_err_corr  = cor;
         dec_done      = 1'b1;
         @(negedge clk);
         dec_done      = 1'b0;
         dec_data_corr = (W*D)'($urandom);
         dec_err_det   = 1'($urandom);
         dec_err_corr  = 1'($urandom);
      end else begin
         repeat (TMO - 1) @(negedge clk);
         chk("timeout_not_early", out_valid, 0);
         @(negedge clk);
         chk("timeout_expired", out_valid, 1);
      end
      drain_frame(exp_rows, e_det, e_unc, stall_at);
      in_valid  = 1'b0;
      exp_frame = sat(exp_frame + 1);
      if (e_unc)   exp_unc = sat(exp_unc + 1);
      if (!dec_on) exp_tmo = sat(exp_tmo + 1);
      chk("frame_cnt", frame_cnt, exp_frame);
      chk("uncorr_cnt", uncorr_cnt, exp_unc);
      chk("timeout_cnt", timeout_cnt, exp_tmo);
      chk("start_count", start_cnt, exp_starts);
   endtask

   initial begin
      row_t         rows[W];
      row_t         rp;
      logic [W-1:0] cp;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_col_par = '0;
      dec_done = 1'b0; dec_data_corr = '0; dec_err_det = 1'b0; dec_err_corr = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dec_start", dec_start, 0);
      chk("rst_dec_data", dec_data, 0);
      chk("rst_dec_row_par", dec_row_par, 0);
      chk("rst_dec_col_par", dec_col_par, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_uncorr_cnt", uncorr_cnt, 0);
      chk("rst_timeout_cnt", timeout_cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      // Clean frame
      rows = '{4'hF, 4'hF, 4'hF, 4'hF};
      run_frame(rows, 4'h0, 4'h0, 1'b1, -1, 1'b0);
      // Single correctable error in the last row
      rows = '{4'hF, 4'hF, 4'hF, 4'hE};
      run_frame(rows, 4'h0, 4'h0, 1'b1, -1, 1'b0);
      // Diagonal of four errors: detected, not correctable
      rows = '{4'h7, 4'hB, 4'hD, 4'hE};
      run_frame(rows, 4'h0, 4'h0, 1'b1, -1, 1'b0);
      // Backpressure mid-drain plus a held in_valid while busy
      for (int i = 0; i < W; i++) rows[i] = row_t'($urandom);
      make_par(rows, rp, cp);
      run_frame(rows, rp, cp, 1'b1, 1, 1'b1);
      // Decoder silent: timeout path
      for (int i = 0; i < W; i++) rows[i] = row_t'($urandom);
      make_par(rows, rp, cp);
      run_frame(rows, rp, cp, 1'b0, -1, 1'b0);

      // Reset after two accepted beats
      send_beat(4'h3, 4'h0);
      send_beat(4'h5, 4'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_dec_start", dec_start, 0);
      chk("mid_rst_dec_data", dec_data, 0);
      chk("mid_rst_frame_cnt", frame_cnt, 0);
      chk("mid_rst_uncorr_cnt", uncorr_cnt, 0);
      chk("mid_rst_timeout_cnt", timeout_cnt, 0);
      rst = 1'b0;
      exp_frame = 0; exp_unc = 0; exp_tmo = 0;
      @(negedge clk);
      chk("mid_rst_idle_ready", in_ready, 1);
      repeat (3) @(negedge clk);
      chk("no_start_aborted", start_cnt, exp_starts);

      rows = '{4'hF, 4'hF, 4'hF, 4'hF};
      run_frame(rows, 4'h0, 4'h0, 1'b1, -1, 1'b0);

      // Randomized frames; enough of them to drive frame_cnt into saturation
      for (int f = 0; f < 14; f++) begin
         int nerr;
         int st;
         bit on;
         for (int i = 0; i < W; i++) rows[i] = row_t'($urandom);
         make_par(rows, rp, cp);
         nerr = $urandom_range(0, 3);
         for (int e = 0; e < nerr; e++) begin
            int ri;
            int bj;
            ri = $urandom_range(0, W - 1);
            bj = $urandom_range(0, D - 1);
            rows[ri][bj] = ~rows[ri][bj];
         end
         on = ($urandom_range(0, 4) != 0);
         st = ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, W - 1)) : -1;
         run_frame(rows, rp, cp, on, st, (f % 2) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute guard against a stuck run
   initial begin
      #2000000;
      $display("FAIL watchdog: observed no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
